mux_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1-muxed datapath port (e.g. register-file write-back or memory port) among 4 requesters.
- Grants exactly one requester at a time and drives the 2-bit mux select.
- Holds the grant until the shared resource signals completion.
- Sits between requester units and the existing 4:1 select mux; its sel output feeds the mux directly.

---
 rtl/arb_pkg.sv | 13 +
 rtl/mux_port_arbiter_rr_pick4.sv | 29 ++
 rtl/mux_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mux_port_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin port arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_port_arbiter_rr_pick4.sv
// Combinational rotate-priority picker: first set request scanning from ptr upward, mod 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [SEL_W-1:0] cand;

  // Scan farthest offset first so the offset nearest ptr overwrites and wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    onehot = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/mux_port_arbiter.sv
// Round-robin arbiter for a shared 4:1-muxed port; holds grant until done.
// Optional watchdog release enabled by `define ARB_TIMEOUT_EN.
module mux_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("mux_port_arbiter: illegal MAX_HOLD/HOLD_W combination");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             release_c;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
  logic              wd_c;

  assign wd_c      = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign release_c = done | wd_c;
  assign timeout   = timeout_q;
`else
  assign release_c = done;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_onehot;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (release_c) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q + SEL_W'(1);
          state_d = RELEASE;
`ifdef ARB_TIMEOUT_EN
          timeout_d = ~done;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Scoreboard bench for mux_port_arbiter: expected grants queued at stimulus, popped by a monitor.
module tb_mux_port_arbiter;

  localparam int unsigned TB_MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [5:0] exp_q[$];
  logic [3:0] prev_gnt = 4'b0;

  mux_port_arbiter #(.MAX_HOLD(TB_MAX_HOLD), .HOLD_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: score each new grant against the queue, and check output consistency every cycle.
  always @(negedge clk) begin
    logic [5:0] e;
    check("busy_vs_gnt", {31'b0, busy}, {31'b0, (gnt != 4'b0)});
    check("gnt_onehot0", {31'b0, $onehot0(gnt)}, 32'd1);
    if (prev_gnt != 4'b0 && gnt != 4'b0 && gnt != prev_gnt)
      check("back_to_back", {28'b0, gnt}, {28'b0, prev_gnt});
    if (prev_gnt == 4'b0 && gnt != 4'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", {28'b0, gnt}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("grant_gnt", {28'b0, gnt}, {28'b0, e[5:2]});
        check("grant_sel", {30'b0, sel}, {30'b0, e[1:0]});
      end
    end
    prev_gnt = gnt;
  end

  task automatic issue(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es);
    req = r;
    exp_q.push_back({eg, es});
  endtask

  task automatic expect_grant(input logic [3:0] eg, input logic [1:0] es);
    exp_q.push_back({eg, es});
  endtask

  task automatic wait_grant(input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0 && n < 20);
    check("grant_latency", n, exp_n);
  endtask

  // Hold grant for 'hold' more edges, pulse done, optionally change req alongside done.
  task automatic finish_txn(input int hold, input logic [1:0] last_sel,
                            input logic upd, input logic [3:0] nreq);
    repeat (hold) @(posedge clk);
    #1 done = 1'b1;
    if (upd) req = nreq;
    @(posedge clk);
    #1 done = 1'b0;
    @(negedge clk);
    check("rel_gnt", {28'b0, gnt}, 32'd0);
    check("rel_busy", {31'b0, busy}, 32'd0);
    check("rel_sel_kept", {30'b0, sel}, {30'b0, last_sel});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst  = 1'b1;
    req  = 4'b0;
    done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", {28'b0, gnt}, 32'd0);
    check("rst_sel", {30'b0, sel}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin with all requesters held: 0,1,2,3,0
    issue(4'b1111, 4'b0001, 2'd0);
    expect_grant(4'b0010, 2'd1);
    expect_grant(4'b0100, 2'd2);
    expect_grant(4'b1000, 2'd3);
    expect_grant(4'b0001, 2'd0);
    for (int i = 0; i < 5; i++) begin
      wait_grant(2);
      finish_txn(1, 2'(i % 4), (i == 4), 4'b0000);
    end

    // Single request (ptr=1), then pointer wrap and repeat-grant cases
    issue(4'b0010, 4'b0010, 2'd1);
    wait_grant(2);
    expect_grant(4'b0001, 2'd0);
    finish_txn(2, 2'd1, 1'b1, 4'b0001);
    wait_grant(2);
    expect_grant(4'b1000, 2'd3);
    finish_txn(1, 2'd0, 1'b1, 4'b1000);
    wait_grant(2);
    expect_grant(4'b1000, 2'd3);
    finish_txn(1, 2'd3, 1'b1, 4'b1000);
    wait_grant(2);
    expect_grant(4'b0100, 2'd2);
    finish_txn(1, 2'd3, 1'b1, 4'b0100);
    wait_grant(2);

    // Requester drops req while granted: grant stays until done
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_on_drop", {28'b0, gnt}, 32'h4);
    end
    finish_txn(0, 2'd2, 1'b0, 4'b0000);

    // done while idle is ignored
    repeat (3) @(posedge clk);
    #1 done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
    @(negedge clk);
    check("idle_done_gnt", {28'b0, gnt}, 32'd0);
    check("idle_done_sel", {30'b0, sel}, 32'd2);
    @(posedge clk);
    #1 issue(4'b1001, 4'b1000, 2'd3);
    wait_grant(2);
    expect_grant(4'b0001, 2'd0);
    finish_txn(1, 2'd3, 1'b1, 4'b0001);
    wait_grant(2);
    expect_grant(4'b0100, 2'd2);
    finish_txn(1, 2'd0, 1'b1, 4'b0100);
    wait_grant(2);

    // Asynchronous reset mid-grant (ptr was 1)
    @(negedge clk);
    #2 rst = 1'b1;
    req = 4'b0000;
    #1;
    check("arst_gnt", {28'b0, gnt}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_sel", {30'b0, sel}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(4'b1001, 4'b0001, 2'd0);
    wait_grant(2);
    expect_grant(4'b0100, 2'd2);
    finish_txn(1, 2'd0, 1'b1, 4'b0100);
    wait_grant(2);
    finish_txn(1, 2'd2, 1'b1, 4'b0000);

`ifdef ARB_TIMEOUT_EN
    begin
      int held = 0;
      issue(4'b0001, 4'b0001, 2'd0);
      wait_grant(2);
      req = 4'b0000;
      while (gnt != 4'b0 && held < 40) begin
        held++;
        @(negedge clk);
      end
      check("wd_hold_cycles", held, TB_MAX_HOLD);
      check("wd_timeout_pulse", {31'b0, timeout}, 32'd1);
      @(negedge clk);
      check("wd_timeout_clear", {31'b0, timeout}, 32'd0);
      repeat (2) @(negedge clk);
      issue(4'b0010, 4'b0010, 2'd1);
      wait_grant(1);
      req = 4'b0000;
      repeat (TB_MAX_HOLD - 1) @(posedge clk);
      #1 done = 1'b1;
      @(posedge clk);
      #1 done = 1'b0;
      @(negedge clk);
      check("wd_coincide_gnt", {28'b0, gnt}, 32'd0);
      check("wd_coincide_timeout", {31'b0, timeout}, 32'd0);
    end
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
